// File: rtl/fsk_modulator_if.sv
// fsk_modulator_if: bit-stream handshake into the FSK modulator
//   din       data bit to modulate
//   din_valid din carries a bit this cycle
//   din_ready modulator FIFO can accept a bit
interface fsk_modulator_if;
  logic din;
  logic din_valid;
  logic din_ready;
  modport master (output din, din_valid, input din_ready);
  modport slave (input din, din_valid, output din_ready);
endinterface

// File: rtl/fsk_modulator.sv
// fsk_modulator: FIFO-buffered binary FSK modulator, 16 clk per symbol
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   s          slave handshake (din, din_valid, din_ready)
//   dout       registered FSK waveform (bit 1 -> period 8, bit 0 -> period 16)
//   sym_strobe registered pulse on the first cycle of every symbol
//   busy       high whenever a symbol is being emitted
// Define FSK_PREAMBLE_EN to prefix each burst with preamble symbols 1,0,1,0.
module fsk_modulator #(
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  fsk_modulator_if.slave s,
  output logic           dout,
  output logic           sym_strobe,
  output logic           busy
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = 1;
`ifdef FSK_PREAMBLE_EN
  typedef enum logic [1:0] {IDLE, PRE, SEND} state_t;
  logic [1:0] pcnt, pcnt_nx;
`else
  typedef enum logic {IDLE, SEND} state_t;
`endif
  state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic [AW:0] wptr, rptr;
  logic mem [DEPTH];
  logic cur, cur_nx, sym_bit, push, pop, empty, full;
  assign empty = wptr == rptr;
  assign full = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign push = s.din_valid && !full;
  assign s.din_ready = !full;
  assign busy = state != IDLE;
  always_ff @(posedge clk)
    if (push) mem[wptr[AW-1:0]] <= s.din;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + ONE;
      if (pop) rptr <= rptr + ONE;
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      cur <= 1'b0;
      dout <= 1'b0;
      sym_strobe <= 1'b0;
`ifdef FSK_PREAMBLE_EN
      pcnt <= '0;
`endif
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      cur <= cur_nx;
      // outputs are computed from next-state values so they line up with cnt
      dout <= state_nx != IDLE && (sym_bit ? cnt_nx[2] : cnt_nx[3]);
      sym_strobe <= state_nx != IDLE && cnt_nx == 4'd0;
`ifdef FSK_PREAMBLE_EN
      pcnt <= pcnt_nx;
`endif
    end
  always_comb begin
    state_nx = state;
    cnt_nx = cnt + 4'd1;
    cur_nx = cur;
    pop = 1'b0;
`ifdef FSK_PREAMBLE_EN
    pcnt_nx = pcnt;
`endif
    case (state)
      IDLE: begin
        cnt_nx = 4'd0;
        if (!empty) begin
          pop = 1'b1;
          cur_nx = mem[rptr[AW-1:0]];
`ifdef FSK_PREAMBLE_EN
          state_nx = PRE;
          pcnt_nx = 2'd0;
`else
          state_nx = SEND;
`endif
        end
      end
`ifdef FSK_PREAMBLE_EN
      PRE: if (cnt == 4'd15) begin
        pcnt_nx = pcnt + 2'd1;
        if (pcnt == 2'd3) state_nx = SEND;
      end
`endif
      SEND: if (cnt == 4'd15) begin
        if (!empty) begin
          pop = 1'b1;
          cur_nx = mem[rptr[AW-1:0]];
        end else state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
`ifdef FSK_PREAMBLE_EN
    // preamble alternates 1,0,1,0 starting from pcnt 0
    sym_bit = state_nx == PRE ? ~pcnt_nx[0] : cur_nx;
`else
    sym_bit = cur_nx;
`endif
  end
endmodule

// File: doc/fsk_modulator.md
FSK_MODULATOR -- requirements
Module: fsk_modulator

Interface
REQ-001 Parameter: DEPTH, 4, input FIFO depth in bits; SHALL be a power of two, >= 2.
REQ-002 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-low.
REQ-004 Port: din  input  1  data bit to modulate.
REQ-005 Port: din_valid  input  1  din is valid this cycle.
REQ-006 Port: din_ready  output  1  FIFO can accept a bit; SHALL equal "FIFO not full" from registered state.
REQ-007 Port: dout  output  1  registered FSK waveform; drives the demodulator's din.
REQ-008 Port: sym_strobe  output  1  registered one-cycle pulse on the first cycle of every emitted symbol.
REQ-009 Port: busy  output  1  high while a symbol is being emitted, i.e. in any state other than IDLE.

Function
REQ-010 A bit SHALL be written to the FIFO when din_valid && din_ready; writes while full SHALL NOT occur.
REQ-011 Each symbol SHALL last exactly 16 clk cycles, indexed by a 4-bit counter cnt = 0..15.
REQ-012 Bit 1: dout SHALL equal cnt[2] (period 8 clk, two rising edges per symbol, at cnt 4 and 12).
REQ-013 Bit 0: dout SHALL equal cnt[3] (period 16 clk, one rising edge per symbol, at cnt 8).
REQ-014 FSM states SHALL be IDLE, PRE (see Configuration) and SEND.
REQ-015 IDLE: dout=0, cnt=0; if FIFO non-empty, pop one bit and go to SEND (or PRE).
REQ-016 A bit pushed into an empty FIFO while in IDLE at cycle N SHALL be popped at N+1; its cnt=0 output cycle SHALL be N+2.
REQ-017 SEND at cnt=15: if FIFO non-empty, pop the next bit and wrap cnt to 0 with no gap cycle; otherwise go to IDLE.
REQ-018 A push and a pop in the same cycle SHALL leave occupancy unchanged; a pop from a full FIFO SHALL raise din_ready on the next cycle.
REQ-019 FIFO pointers SHALL be log2(DEPTH)+1 bits wide and wrap modulo 2*DEPTH; full/empty SHALL be derived from MSB and index comparison.
REQ-020 Bits SHALL be emitted in FIFO order, never dropped or duplicated.
REQ-021 sym_strobe SHALL be 1 exactly on cycles where cnt=0 and state is PRE or SEND.

Reset
REQ-022 While rst=0: dout=0, sym_strobe=0, busy=0, cnt=0, state=IDLE, FIFO empty, din_ready=1.
REQ-023 Reset asserted mid-symbol SHALL abort immediately; FIFO contents SHALL be discarded.
REQ-024 After rst deasserts, the block SHALL be in IDLE with no residual symbol output.

Configuration
REQ-025 Macro FSK_PREAMBLE_EN: when defined, each IDLE->active transition SHALL enter PRE and emit four preamble symbols 1,0,1,0 (64 cycles) before the first data symbol; the data bit SHALL be popped on the IDLE->PRE transition and held until PRE ends.
REQ-026 Consecutive data symbols with no intervening IDLE SHALL NOT repeat the preamble.
REQ-027 Without FSK_PREAMBLE_EN, the PRE state SHALL be absent and IDLE SHALL go directly to SEND.

Verification
REQ-028 Reset, then push 1 at cycle 0 -> sym_strobe at cycle 2; dout 0,0,0,0,1,1,1,1,0,0,0,0,1,1,1,1 over cycles 2..17; busy=0 at cycle 18.
REQ-029 Push 0 into an empty FIFO -> dout=0 for cnt 0..7, 1 for cnt 8..15; exactly one rising edge in the symbol.
REQ-030 Push 1,0,1,1,0 back to back with DEPTH=4 -> din_ready falls after the 4th stored bit; the stream is emitted in order with no gap cycles; sym_strobe every 16 cycles.
REQ-031 Assert rst at cnt=6 of the second of three queued symbols -> dout=0 and din_ready=1 immediately; no further symbols after release.
REQ-032 Build with FSK_PREAMBLE_EN and push 0 -> 64 cycles of preamble 1,0,1,0, then one 0-symbol; sym_strobe fires 5 times.
REQ-033 Loop fsk_modulator into the existing demodulator with shared clk/rst and random 200-bit input -> demodulated bits match the input sequence.
